// File: rtl/pipeline_pkg.sv
// Shared defaults and sizing helper for the elastic delay pipeline.
package pipeline_pkg;
  localparam int DEF_LATENCY   = 4;
  localparam int DEF_WORD_SIZE = 18;

  // Bits needed to count 0..latency valid stages.
  function automatic int occ_width(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid flag plus payload, with clear and load controls.
module pipe_stage #(
  parameter int WIDTH = 18
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Payload only moves with a real word, so a bubble keeps stale data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/elastic_delay_pipe.sv
// Fixed-depth delay line with valid/ready flow control, optional bubble collapsing and flush.
// Handshake: a word moves across a port only on a cycle where valid && ready at the rising edge.
module elastic_delay_pipe
  import pipeline_pkg::*;
#(
  parameter int LATENCY   = DEF_LATENCY,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int COLLAPSE  = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WORD_SIZE-1:0]           in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WORD_SIZE-1:0]           out_data,
  input  logic                           flush,
  output logic [occ_width(LATENCY)-1:0]  occupancy
);
  localparam int OW = occ_width(LATENCY);

  logic [LATENCY-1:0]   stage_valid;
  logic [LATENCY-1:0]   can_take;
  logic [WORD_SIZE-1:0] stage_data [LATENCY];
  logic                 in_xfer, out_xfer;
  logic [OW-1:0]        occ_q, occ_d;

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    logic                 src_valid;
    logic [WORD_SIZE-1:0] src_data;

    if (i == LATENCY - 1) begin : g_entry
      assign src_valid = in_xfer;
      assign src_data  = in_data;
    end else begin : g_inner
      assign src_valid = stage_valid[i+1];
      assign src_data  = stage_data[i+1];
    end

    // A slot can refill when any slot at or below it is empty, or the sink is draining.
    if (COLLAPSE != 0) begin : g_collapse
      assign can_take[i] = out_ready | ~(&stage_valid[i:0]);
    end else begin : g_lockstep
      assign can_take[i] = out_ready | ~stage_valid[0];
    end

    pipe_stage #(.WIDTH(WORD_SIZE)) u_stage (
      .clk_i   (clock),
      .rst_n_i (reset),
      .clear_i (flush),
      .load_i  (can_take[i]),
      .valid_i (src_valid),
      .data_i  (src_data),
      .valid_o (stage_valid[i]),
      .data_o  (stage_data[i])
    );
  end

  assign in_ready  = reset & ~flush & can_take[LATENCY-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = stage_valid[0];
  assign out_data  = stage_data[0];
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush)                    occ_d = '0;
    else if (in_xfer & ~out_xfer) occ_d = occ_q + OW'(1);
    else if (~in_xfer & out_xfer) occ_d = occ_q - OW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy = occ_q;
endmodule
